// File: rtl/jericalla_seq.sv
// jericalla_seq -- instruction sequencer for the Jericalla ROM/ALU/RAM datapath.
//
// Instruction words enter a small FIFO through a valid/ready handshake. Each
// word is executed as a compute cycle (EXEC, RAM write enable forced low)
// followed by a write cycle (WRITE, word driven as-is), so the RAM write
// enable is a clean one-cycle pulse. The zero flag is captured in EXEC, the
// RAM readback in WRITE, and every completed word bumps exec_count.
//
// Optional feature: define JERICALLA_SEQ_ZF_HALT_EN to stop the sequencer in a
// HALT state after any instruction whose zero flag was set; i_clear_halt
// resumes. Without the macro there is no HALT state and o_halted is 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_in_valid        i_in_instr holds a word to enqueue
//   o_in_ready        queue not full (registered)
//   i_in_instr[16:0]  {ram_addr, alu_sel, rom_addr2, rom_addr1, wen}
//   o_dp_instr[16:0]  registered instruction bus to the datapath
//   i_dp_zf           datapath zero flag for o_dp_instr
//   i_dp_data[31:0]   datapath RAM readback for o_dp_instr
//   o_done            one-cycle pulse: o_result / o_result_zf updated
//   o_result[31:0]    RAM readback of the last completed instruction
//   o_result_zf       zero flag of the last completed instruction
//   o_busy            FSM not idle or queue not empty
//   o_exec_count      completed instruction count (wraps)
//   o_halted          stopped on a zero result (halt feature only)
//   i_clear_halt      pulse to leave the halted state
module jericalla_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [16:0]      i_in_instr,
  output logic [16:0]      o_dp_instr,
  input  logic             i_dp_zf,
  input  logic [31:0]      i_dp_data,
  output logic             o_done,
  output logic [31:0]      o_result,
  output logic             o_result_zf,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_exec_count,
  output logic             o_halted,
  input  logic             i_clear_halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
`ifdef JERICALLA_SEQ_ZF_HALT_EN
    S_WRITE = 2'd2,
    S_HALT  = 2'd3
`else
    S_WRITE = 2'd2
`endif
  } state_t;

  // ---------------- instruction queue ----------------
  logic [16:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [16:0]   w_head;

  assign w_empty = (r_count == '0);
  assign w_push  = i_in_valid && r_in_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      // Registered from the next count so ready is already low in the first
      // full cycle; a push into a full queue can never be accepted.
      r_in_ready <= (w_count_next != FULL_CNT);
    end
  end

  // ---------------- sequencer FSM ----------------
  state_t      r_state;
  state_t      w_state_next;
  logic [16:0] r_cur;
  logic [16:0] w_cur_next;
  logic [16:0] r_dp_instr;
  logic [16:0] w_dp_next;
  logic        r_zf_q;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_result_zf;
  logic [CNT_W-1:0] r_exec_count;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
`ifdef JERICALLA_SEQ_ZF_HALT_EN
        if (r_zf_q) begin
          w_state_next = S_HALT;
        end else
`endif
        if (!w_empty) begin
          // Chain straight into the next EXEC: no idle bubble.
          w_pop        = 1'b1;
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
`ifdef JERICALLA_SEQ_ZF_HALT_EN
      S_HALT: begin
        if (i_clear_halt) w_state_next = S_IDLE;
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // dp_instr is a register, so its next value is chosen from the next state.
  always_comb begin
    w_cur_next = w_pop ? w_head : r_cur;
    w_dp_next  = '0;
    case (w_state_next)
      S_EXEC:  w_dp_next = {w_cur_next[16:1], 1'b0};
      S_WRITE: w_dp_next = w_cur_next;
      default: w_dp_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_dp_instr   <= '0;
      r_zf_q       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_result_zf  <= 1'b0;
      r_exec_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cur      <= w_cur_next;
      r_dp_instr <= w_dp_next;
      r_done     <= (r_state == S_WRITE);
      if (r_state == S_EXEC) begin
        r_zf_q <= i_dp_zf;
      end
      if (r_state == S_WRITE) begin
        r_result     <= i_dp_data;
        r_result_zf  <= r_zf_q;
        r_exec_count <= r_exec_count + 1'b1;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_dp_instr   = r_dp_instr;
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_result_zf  = r_result_zf;
  assign o_exec_count = r_exec_count;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;

`ifdef JERICALLA_SEQ_ZF_HALT_EN
  assign o_halted = (r_state == S_HALT);
`else
  logic w_unused_clear_halt;
  assign w_unused_clear_halt = i_clear_halt;
  assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_jericalla_seq.sv
// Testbench for jericalla_seq: directed latency / burst / reset / halt
// scenarios followed by a randomized stream, all scored against a queue-based
// model of the sequencer's observable behaviour.
`timescale 1ns/1ps
module tb_jericalla_seq;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [16:0]      in_instr = '0;
  logic [16:0]      dp_instr;
  logic             dp_zf;
  logic [31:0]      dp_data;
  logic             done;
  logic [31:0]      result;
  logic             result_zf;
  logic             busy;
  logic [CNT_W-1:0] exec_count;
  logic             halted;
  logic             clear_halt;
  logic             auto_clr = 1'b0;
  logic             man_clr = 1'b0;
  logic             auto_clear_en = 1'b0;
  logic             stub_const = 1'b1;

  int               n_checks = 0;
  int               n_fail = 0;
  logic [16:0]      exp_q[$];
  logic [CNT_W-1:0] model_count = '0;
  int               cyc = 0;
  int               done_cycles[$];
  logic             not_ready_seen = 1'b0;

  jericalla_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_instr   (in_instr),
    .o_dp_instr   (dp_instr),
    .i_dp_zf      (dp_zf),
    .i_dp_data    (dp_data),
    .o_done       (done),
    .o_result     (result),
    .o_result_zf  (result_zf),
    .o_busy       (busy),
    .o_exec_count (exec_count),
    .o_halted     (halted),
    .i_clear_halt (clear_halt)
  );

  always #5 clk = ~clk;

  // Datapath stub: constant DEADBEEF / zf=0, or a hash of the bus with
  // zf = alu_sel[3] & alu_sel[2].
  assign dp_data    = stub_const ? 32'hDEAD_BEEF : (32'hDEAD_BEEF ^ {dp_instr[14:0], dp_instr});
  assign dp_zf      = stub_const ? 1'b0 : (dp_instr[12] & dp_instr[11]);
  assign clear_halt = auto_clr | man_clr;

  function automatic logic [31:0] exp_data(input logic [16:0] w);
    return stub_const ? 32'hDEAD_BEEF : (32'hDEAD_BEEF ^ {w[14:0], w});
  endfunction

  function automatic logic exp_zf(input logic [16:0] w);
    return stub_const ? 1'b0 : (w[12] & w[11]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Release a halt one cycle after it is seen (random phase only).
  initial forever begin
    @(negedge clk);
    auto_clr = auto_clear_en && halted;
  end

  // Scoreboard: every done pulse retires the oldest accepted word.
  initial forever begin : monitor
    logic [16:0] w;
    @(negedge clk);
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        model_count = model_count + 1'b1;
        check_eq("result", result, exp_data(w));
        check_eq("result_zf", {31'd0, result_zf}, {31'd0, exp_zf(w)});
        check_eq("exec_count", 32'(exec_count), 32'(model_count));
`ifdef JERICALLA_SEQ_ZF_HALT_EN
        check_eq("halted_at_done", {31'd0, halted}, {31'd0, exp_zf(w)});
`else
        check_eq("halted_at_done", {31'd0, halted}, 32'd0);
`endif
        done_cycles.push_back(cyc);
        $display("done #%0d cyc=%0d instr=%05h result=%08h zf=%0b",
                 model_count, cyc, w, result, result_zf);
      end
    end
  end

  // Called at a negedge; returns at a later negedge once the word is accepted.
  task automatic push_word(input logic [16:0] w);
    int t = 0;
    in_instr = w;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      not_ready_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("push_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      exp_q.push_back(w);
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    @(negedge clk);
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!done) check_eq(tag, {31'd0, done}, 32'd1);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [16:0] dp_seen [5];
  logic        done_seen [5];
  logic [16:0] exp_dp [5];
  logic [16:0] word_a;
  logic [16:0] word_b;
  logic [16:0] rw;
  int          t0;
  int          ndone;
  logic [CNT_W-1:0] cnt_before;

  initial begin
    exp_dp[0] = 17'h00000; exp_dp[1] = 17'h06442; exp_dp[2] = 17'h06443;
    exp_dp[3] = 17'h00000; exp_dp[4] = 17'h00000;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_dp_instr", {15'd0, dp_instr}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_result_zf", {31'd0, result_zf}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_exec_count", 32'(exec_count), 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);

    // ---- single instruction: latency and dp_instr sequence ----
    stub_const = 1'b1;
    push_word(17'h06443);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dp_seen[k]   = dp_instr;
      done_seen[k] = done;
      @(negedge clk);
    end
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("single_dp%0d", k), {15'd0, dp_seen[k]}, {15'd0, exp_dp[k]});
      check_eq($sformatf("single_done%0d", k), {31'd0, done_seen[k]}, (k == 3) ? 32'd1 : 32'd0);
      if (done_seen[k]) ndone++;
    end
    check_eq("single_done_count", ndone, 32'd1);
    check_eq("single_exec_count", 32'(exec_count), 32'd1);
    wait_idle("single_idle", 50);

    // ---- burst of 8: queue fills, done every 2 cycles, in order ----
    stub_const = 1'b0;
    not_ready_seen = 1'b0;
    done_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      rw = 17'($urandom);
      rw[12] = 1'b0;
      push_word(rw);
    end
    in_valid = 1'b0;
    wait_idle("burst_idle", 100);
    check_eq("burst_ready_dropped", {31'd0, not_ready_seen}, 32'd1);
    check_eq("burst_done_count", done_cycles.size(), 32'd8);
    for (int i = 1; i < done_cycles.size(); i++) begin
      check_eq($sformatf("burst_spacing%0d", i), done_cycles[i] - done_cycles[i-1], 32'd2);
    end
    check_eq("burst_exec_count", 32'(exec_count), 32'(model_count));

    // ---- reset during the WRITE of the second of three ----
    for (int i = 0; i < 3; i++) begin
      rw = 17'($urandom);
      rw[12] = 1'b0;
      if (i == 1) word_a = rw;
      push_word(rw);
    end
    in_valid = 1'b0;
    wait_done("rst_first_done", 20);
    @(negedge clk);
    check_eq("rst_mid_write_dp", {15'd0, dp_instr}, {15'd0, word_a});
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_count = '0;
    check_eq("rst_mid_dp", {15'd0, dp_instr}, 32'd0);
    check_eq("rst_mid_count", 32'(exec_count), 32'd0);
    check_eq("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("post_rst_dp", {15'd0, dp_instr}, 32'd0);
    check_eq("post_rst_count", 32'(exec_count), 32'd0);
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

    // ---- zero-flag halt (or plain back-to-back without the feature) ----
    word_a = 17'h0B843;   // alu_sel = 4'hC -> stub zf = 1
    word_b = 17'h0C469;   // alu_sel = 4'h2 -> stub zf = 0
    push_word(word_a);
    push_word(word_b);
    in_valid = 1'b0;
    wait_done("halt_first_done", 20);
    t0 = cyc;
    cnt_before = model_count;
`ifdef JERICALLA_SEQ_ZF_HALT_EN
    repeat (5) @(negedge clk);
    check_eq("halt_held", {31'd0, halted}, 32'd1);
    check_eq("halt_dp_zero", {15'd0, dp_instr}, 32'd0);
    check_eq("halt_count_held", 32'(exec_count), 32'(cnt_before));
    man_clr = 1'b1;
    @(negedge clk);
    man_clr = 1'b0;
    wait_done("halt_second_done", 20);
    check_eq("halt_released", {31'd0, halted}, 32'd0);
`else
    wait_done("nohalt_second_done", 20);
    check_eq("nohalt_spacing", cyc - t0, 32'd2);
    check_eq("nohalt_halted", {31'd0, halted}, 32'd0);
`endif
    check_eq("halt_exec_count", 32'(exec_count), 32'(cnt_before + 1'b1));
    wait_idle("halt_idle", 50);

    // ---- randomized stream ----
    auto_clear_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_word(17'($urandom));
    end
    in_valid = 1'b0;
    wait_idle("rand_idle", 2000);
    check_eq("rand_drained", exp_q.size(), 32'd0);
    check_eq("rand_exec_count", 32'(exec_count), 32'(model_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
